// File: rtl/i2s_audio_rx.sv
// I2S master-mode ADC receiver: generates mclk/sck/lrck and deserializes stereo 16-bit frames.
// Optional mono mix output enabled by defining I2S_RX_MONO_MIX_EN.
module i2s_audio_rx #(
    parameter int unsigned MCLK_DIV_LOG2 = 2,
    parameter int unsigned SCK_DIV_LOG2  = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    input  logic        audio_sdout,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    output logic [15:0] mono_data
);

    localparam int unsigned CW        = SCK_DIV_LOG2 + 5;
    localparam int unsigned SW        = 16;
    localparam int unsigned STROBE_I  = (1 << (SCK_DIV_LOG2 - 1)) + 2;
    localparam logic [SCK_DIV_LOG2-1:0] STROBE_PH = SCK_DIV_LOG2'(STROBE_I);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic [1:0]    sync_q;
    logic [1:0]    state_q, state_nxt_c;
    logic [SW-1:0] shift_q, shift_nxt_c;
    logic [SW-1:0] hold_q, hold_nxt_c;
    logic          frame_done_c;
    logic          strobe_c;
    logic          lrck_c;
    logic [3:0]    slot_c;
    logic [SW-1:0] word_c;

    assign cnt_nxt_c = cnt + CW'(1);

    // Outputs are registered from the next count so they track cnt in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
            sync_q     <= '0;
        end else begin
            cnt        <= cnt_nxt_c;
            audio_mclk <= cnt_nxt_c[MCLK_DIV_LOG2-1];
            audio_sck  <= cnt_nxt_c[SCK_DIV_LOG2-1];
            audio_lrck <= cnt_nxt_c[CW-1];
            sync_q     <= {sync_q[0], audio_sdout};
        end
    end

    // Strobe lands two clocks after the sck rising edge to cover the synchronizer.
    assign strobe_c = (cnt[SCK_DIV_LOG2-1:0] == STROBE_PH);
    assign lrck_c   = cnt[CW-1];
    assign slot_c   = cnt[SCK_DIV_LOG2+3:SCK_DIV_LOG2];
    assign word_c   = {shift_q[SW-2:0], sync_q[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt_c;
            shift_q <= shift_nxt_c;
            hold_q  <= hold_nxt_c;
        end
    end

    always_comb begin
        state_nxt_c  = state_q;
        shift_nxt_c  = shift_q;
        hold_nxt_c   = hold_q;
        frame_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe_c && !lrck_c && (slot_c == 4'd1)) begin
                    state_nxt_c = ST_LEFT;
                    shift_nxt_c = word_c;
                end
            end
            ST_LEFT: begin
                if (strobe_c) begin
                    if (lrck_c && (slot_c == 4'd0)) begin
                        hold_nxt_c  = word_c;
                        shift_nxt_c = '0;
                        state_nxt_c = ST_RIGHT;
                    end else begin
                        shift_nxt_c = word_c;
                    end
                end
            end
            ST_RIGHT: begin
                if (strobe_c) begin
                    if (!lrck_c && (slot_c == 4'd0)) begin
                        frame_done_c = 1'b1;
                        shift_nxt_c  = '0;
                        state_nxt_c  = ST_LEFT;
                    end else begin
                        shift_nxt_c = word_c;
                    end
                end
            end
            default: state_nxt_c = ST_IDLE;
        endcase
    end

    logic load_c;
    assign load_c = frame_done_c && (!out_valid || out_ready);

    // Output frame register: a completion against a stalled consumer is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_done_c) begin
            if (load_c) begin
                out_left  <= hold_q;
                out_right <= word_c;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef I2S_RX_MONO_MIX_EN
    logic [SW:0] sum_c;
    assign sum_c = {hold_q[SW-1], hold_q} + {word_c[SW-1], word_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            mono_data <= '0;
        end else if (load_c) begin
            mono_data <= SW'(sum_c >> 1);
        end
    end
`else
    assign mono_data = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Self-checking bench for i2s_audio_rx: codec model plus frame-level reference model.
// Mono expectations follow I2S_RX_MONO_MIX_EN.
module tb_i2s_audio_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        audio_sdout = 1'b0;
    logic        out_ready = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck;
    logic [15:0] out_left, out_right, mono_data;
    logic        out_valid, overrun;

`ifdef I2S_RX_MONO_MIX_EN
    localparam bit MONO_EN = 1'b1;
`else
    localparam bit MONO_EN = 1'b0;
`endif

    i2s_audio_rx dut (
        .clk        (clk),
        .rst        (rst),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdout(audio_sdout),
        .out_left   (out_left),
        .out_right  (out_right),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .mono_data  (mono_data)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          tcnt = 0;
    int          first_valid = -1;
    logic [15:0] fl [16];
    logic [15:0] fr [16];
    logic        m_valid, m_ovr;
    logic [15:0] m_l, m_r, m_mono;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] mono;
    } vec_t;
    vec_t tv [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, tcnt, act, exp);
        end
    endtask

    function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return MONO_EN ? 16'(s >>> 1) : 16'h0000;
    endfunction

    // Codec: slot 0 of each half carries the LSB of the previous word, slots 1..15 bits 15..1.
    function automatic logic codec_bit(input int n);
        int fi, p, h, s;
        logic [15:0] w;
        fi = n / 1024;
        p  = n % 1024;
        h  = p / 512;
        s  = (p % 512) / 32;
        if (s == 0) begin
            if (h == 0) w = (fi == 0) ? 16'h0000 : fr[(fi - 1) % 16];
            else        w = fl[fi % 16];
            return w[0];
        end
        w = (h != 0) ? fr[fi % 16] : fl[fi % 16];
        return w[16 - s];
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic tick(input logic rdy);
        logic [31:0] t;
        int fi;
        @(negedge clk);
        t = tcnt;
        chk("clocks", {audio_mclk, audio_sck, audio_lrck}, {t[1], t[4], t[9]});
        chk("valid", out_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        chk("left", out_left, m_l);
        chk("right", out_right, m_r);
        chk("mono", mono_data, m_mono);
        if (out_valid && first_valid < 0) first_valid = tcnt;
        out_ready   = rdy;
        audio_sdout = codec_bit(tcnt);
        if (tcnt >= 1024 && (tcnt % 1024) == 18) begin
            fi = tcnt / 1024 - 1;
            if (!m_valid || rdy) begin
                m_l     = fl[fi % 16];
                m_r     = fr[fi % 16];
                m_mono  = mono_of(m_l, m_r);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        tcnt++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst         = 1'b1;
        out_ready   = 1'b0;
        audio_sdout = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_outs", {out_valid, overrun, audio_mclk, audio_sck, audio_lrck}, 32'h0);
            chk("rst_data", {out_left, out_right}, 32'h0);
            chk("rst_mono", mono_data, 32'h0);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        tcnt        = 0;
        first_valid = -1;
        m_valid = 1'b0; m_ovr = 1'b0;
        m_l = '0; m_r = '0; m_mono = '0;
    endtask

    task automatic rand_words();
        for (int i = 0; i < 16; i++) begin
            fl[i] = 16'($urandom);
            fr[i] = 16'($urandom);
        end
    endtask

    initial begin
        tv[0] = '{16'h7FFF, 16'h0001, MONO_EN ? 16'h4000 : 16'h0000};
        tv[1] = '{16'h8000, 16'h8000, MONO_EN ? 16'h8000 : 16'h0000};
        tv[2] = '{16'hFFFF, 16'h0000, MONO_EN ? 16'hFFFF : 16'h0000};
        tv[3] = '{16'hA5C3, 16'h3C5A, MONO_EN ? 16'hF10E : 16'h0000};
        tv[4] = '{16'h0001, 16'h0002, MONO_EN ? 16'h0001 : 16'h0000};

        // Free run with a constant stereo pattern and ready held high.
        for (int i = 0; i < 16; i++) begin fl[i] = 16'hA5C3; fr[i] = 16'h3C5A; end
        do_reset(3);
        while (tcnt <= 1043) tick(1'b1);
        chk("first_valid", first_valid, 1043);
        chk("first_left", out_left, 16'hA5C3);
        chk("first_right", out_right, 16'h3C5A);
        while (tcnt < 4 * 1024 + 40) tick(1'b1);

        // Stalled consumer: second completion is dropped and overrun sticks.
        for (int i = 0; i < 16; i++) begin fl[i] = 16'(2 * i + 1); fr[i] = 16'(2 * i + 2); end
        do_reset(2);
        while (tcnt < 3100) tick(1'b0);
        chk("stall_left", out_left, 16'h0001);
        chk("stall_right", out_right, 16'h0002);
        chk("stall_ovr", overrun, 1'b1);
        chk("stall_valid", out_valid, 1'b1);
        while (tcnt < 4200) tick(1'b1);

        // Ready asserted exactly in a completion cycle while valid is high.
        rand_words();
        do_reset(2);
        while (tcnt < 2066) tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        chk("coinc_valid", out_valid, 1'b1);
        chk("coinc_left", out_left, fl[1]);
        chk("coinc_right", out_right, fr[1]);
        chk("coinc_ovr", overrun, 1'b0);
        while (tcnt < 3200) tick(1'b1);

        // Mid-frame reset at cnt = 700.
        rand_words();
        do_reset(2);
        while (tcnt < 700) tick(1'b1);
        rand_words();
        do_reset(1);
        while (tcnt <= 1100) tick(1'b1);
        chk("rst_mid_first_valid", first_valid, 1043);

        // Random words with random ready stretches.
        rand_words();
        do_reset(2);
        while (tcnt < 9 * 1024 + 100) begin
            logic rdy;
            int len;
            rdy = 1'($urandom_range(0, 1));
            len = int'($urandom_range(50, 2500));
            for (int k = 0; k < len; k++) tick(rdy);
        end

        // Table-driven frames including mono-mix boundaries.
        for (int i = 0; i < 5; i++) begin fl[i] = tv[i].l; fr[i] = tv[i].r; end
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            while (tcnt <= 1024 * (i + 1) + 19) tick(1'b1);
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_left", out_left, tv[i].l);
            chk("tbl_right", out_right, tv[i].r);
            chk("tbl_mono", mono_data, tv[i].mono);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
